// File: rtl/filter_bank.sv
// rtl/filter_bank.sv - multi-channel glitch filter with rise/fall pulses and sample tick
// Define FILTER_BANK_IRQ_EN to add sticky per-channel change flags (irq_clr/irq_pend/irq).
module filter_bank #(
  parameter int CHANNELS    = 4,
  parameter int DEPTH       = 3,
  parameter int PRESCALE    = 1,
  parameter int SYNC_STAGES = 0
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [CHANNELS-1:0] sig_in,
  output logic [CHANNELS-1:0] sig_out,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall,
  output logic                tick
`ifdef FILTER_BANK_IRQ_EN
  ,
  input  logic [CHANNELS-1:0] irq_clr,
  output logic [CHANNELS-1:0] irq_pend,
  output logic                irq
`endif
);
  localparam int PCW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PCW-1:0]      pcnt_q, pcnt_d;
  logic [CHANNELS-1:0] s_in;
  logic [DEPTH-1:0]    win_q [CHANNELS];
  logic [DEPTH-1:0]    win_d [CHANNELS];
  logic [CHANNELS-1:0] out_q, out_d;
  logic [CHANNELS-1:0] rise_q, rise_d;
  logic [CHANNELS-1:0] fall_q, fall_d;

  assign tick   = (pcnt_q == PCW'(PRESCALE - 1));
  assign pcnt_d = tick ? '0 : pcnt_q + PCW'(1);

  // Synchroniser runs every clock; only the window shift is gated by tick.
  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign s_in = sig_in;
    end else begin : g_sync
      logic [CHANNELS-1:0] sync_q [SYNC_STAGES];
      always_ff @(posedge clock) begin
        if (!reset) begin
          for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
          sync_q[0] <= sig_in;
          for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
      end
      assign s_in = sync_q[SYNC_STAGES-1];
    end
  endgenerate

  // Decision looks at the registered window, so the sample shifted in on this edge counts next edge.
  always_comb begin
    out_d  = out_q;
    rise_d = '0;
    fall_d = '0;
    for (int ch = 0; ch < CHANNELS; ch++) begin
      win_d[ch] = tick ? {win_q[ch][DEPTH-2:0], s_in[ch]} : win_q[ch];
      if ((&win_q[ch]) && !out_q[ch]) begin
        out_d[ch]  = 1'b1;
        rise_d[ch] = 1'b1;
      end else if (!(|win_q[ch]) && out_q[ch]) begin
        out_d[ch]  = 1'b0;
        fall_d[ch] = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      pcnt_q <= '0;
      out_q  <= '0;
      rise_q <= '0;
      fall_q <= '0;
      for (int ch = 0; ch < CHANNELS; ch++) win_q[ch] <= '0;
    end else begin
      pcnt_q <= pcnt_d;
      out_q  <= out_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
      win_q  <= win_d;
    end
  end

  assign sig_out = out_q;
  assign rise    = rise_q;
  assign fall    = fall_q;

`ifdef FILTER_BANK_IRQ_EN
  logic [CHANNELS-1:0] pend_q, pend_d;

  // A new edge pulse wins over a clear arriving in the same cycle.
  assign pend_d = (pend_q & ~irq_clr) | rise_q | fall_q;

  always_ff @(posedge clock) begin
    if (!reset) pend_q <= '0;
    else        pend_q <= pend_d;
  end

  assign irq_pend = pend_q;
  assign irq      = |pend_q;
`endif

endmodule

// File: tb/tb_filter_bank.sv
// tb/tb_filter_bank.sv - scoreboard bench for filter_bank (default and prescaled/synchronised instances)
module tb_filter_bank;
  typedef struct {
    int         cyc;
    int         unit;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] c;
    logic       d;
    string      nm;
  } exp_t;

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] sig_in;
  logic [3:0] sig_out, rise, fall;
  logic       tick;
  logic [0:0] sig4, so4, ri4, fa4;
  logic       tk4;
`ifdef FILTER_BANK_IRQ_EN
  logic [3:0] irq_clr_r, irq_pend_w;
  logic       irq_w;
  logic [0:0] pend4_w;
  logic       irq4_w;
`endif

  int   cyc   = 0;
  int   n_vec = 0;
  int   n_bad = 0;
  exp_t sb[$];

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  filter_bank dut (
    .clock   (clock),
    .reset   (reset),
    .sig_in  (sig_in),
    .sig_out (sig_out),
    .rise    (rise),
    .fall    (fall),
    .tick    (tick)
`ifdef FILTER_BANK_IRQ_EN
    ,
    .irq_clr (irq_clr_r),
    .irq_pend(irq_pend_w),
    .irq     (irq_w)
`endif
  );

  filter_bank #(.CHANNELS(1), .DEPTH(3), .PRESCALE(4), .SYNC_STAGES(2)) dut4 (
    .clock   (clock),
    .reset   (reset),
    .sig_in  (sig4),
    .sig_out (so4),
    .rise    (ri4),
    .fall    (fa4),
    .tick    (tk4)
`ifdef FILTER_BANK_IRQ_EN
    ,
    .irq_clr (1'b0),
    .irq_pend(pend4_w),
    .irq     (irq4_w)
`endif
  );

  task automatic push(input int unit, input logic [3:0] a, input logic [3:0] b,
                      input logic [3:0] c, input logic d, input string nm);
    exp_t e;
    e.cyc = cyc + 1; e.unit = unit; e.a = a; e.b = b; e.c = c; e.d = d; e.nm = nm;
    sb.push_back(e);
  endtask

  task automatic step(input logic rst, input logic [3:0] din, input logic [3:0] clr,
                      input logic [3:0] so, input logic [3:0] ri, input logic [3:0] fa,
                      input string nm);
    @(posedge clock); #1;
    reset  = rst;
    sig_in = din;
`ifdef FILTER_BANK_IRQ_EN
    irq_clr_r = clr;
`endif
    push(0, so, ri, fa, 1'b1, nm);
  endtask

`ifdef FILTER_BANK_IRQ_EN
  task automatic stepi(input logic [3:0] din, input logic [3:0] clr, input logic [3:0] so,
                       input logic [3:0] ri, input logic [3:0] fa, input logic [3:0] pend,
                       input string nm);
    step(1'b1, din, clr, so, ri, fa, nm);
    push(2, pend, 4'h0, 4'h0, |pend, {nm, "_irq"});
  endtask
`endif

  task automatic step4(input logic rst, input logic din, input logic so, input logic ri,
                       input logic fa, input logic tk, input string nm);
    @(posedge clock); #1;
    reset = rst;
    sig4  = din;
    push(1, {3'b0, so}, {3'b0, ri}, {3'b0, fa}, tk, nm);
  endtask

  always @(negedge clock) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      exp_t        e;
      logic [12:0] act, req;
      e   = sb.pop_front();
      req = {e.a, e.b, e.c, e.d};
      case (e.unit)
        0:       act = {sig_out, rise, fall, tick};
        1:       act = {3'b0, so4, 3'b0, ri4, 3'b0, fa4, tk4};
`ifdef FILTER_BANK_IRQ_EN
        default: act = {irq_pend_w, 8'h00, irq_w};
`else
        default: act = '0;
`endif
      endcase
      n_vec++;
      if (e.cyc != cyc || act !== req) begin
        n_bad++;
        $display("FAIL %s cyc %0d (due %0d): got %h required %h", e.nm, cyc, e.cyc, act, req);
      end
    end
  end

  int t2_in  [16] = '{1, 1, 0, 1, 1, 0, 1, 1, 1, 0, 1, 0, 0, 0, 0, 0};
  int t2_out [16] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 0, 0};

  initial begin
    reset  = 1'b0;
    sig_in = 4'hF;
    sig4   = 1'b0;
`ifdef FILTER_BANK_IRQ_EN
    irq_clr_r = 4'h0;
`endif

    repeat (3) step(1'b0, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, "t1_reset");
    repeat (3) step(1'b1, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, "t1_fill");
    step(1'b1, 4'hF, 4'h0, 4'hF, 4'hF, 4'h0, "t1_rise");
    step(1'b1, 4'hF, 4'h0, 4'hF, 4'h0, 4'h0, "t1_hold");

    repeat (3) step(1'b1, 4'h9, 4'h0, 4'hF, 4'h0, 4'h0, "prep_hold");
    step(1'b1, 4'h9, 4'h0, 4'h9, 4'h0, 4'h6, "prep_fall");
    step(1'b1, 4'h9, 4'h0, 4'h9, 4'h0, 4'h0, "prep_settle");

    for (int i = 0; i < 16; i++) begin
      step(1'b1, (t2_in[i] != 0) ? 4'hB : 4'h9, 4'h0, (t2_out[i] != 0) ? 4'hB : 4'h9,
           (i == 9) ? 4'h2 : 4'h0, (i == 14) ? 4'h2 : 4'h0, "t2_ch1");
    end

    repeat (3) step(1'b1, 4'h5, 4'h0, 4'h9, 4'h0, 4'h0, "t3_wait");
    step(1'b1, 4'h5, 4'h0, 4'h5, 4'h4, 4'h8, "t3_edges");
    step(1'b1, 4'h5, 4'h0, 4'h5, 4'h0, 4'h0, "t3_settle");

    repeat (3) step(1'b1, 4'h4, 4'h0, 4'h5, 4'h0, 4'h0, "t5_prep");
    step(1'b1, 4'h4, 4'h0, 4'h4, 4'h0, 4'h1, "t5_fall");
    step(1'b1, 4'h4, 4'h0, 4'h4, 4'h0, 4'h0, "t5_low");
    repeat (2) step(1'b1, 4'h5, 4'h0, 4'h4, 4'h0, 4'h0, "t5_two_ones");
    step(1'b0, 4'h5, 4'h0, 4'h0, 4'h0, 4'h0, "t5_reset");
    step(1'b1, 4'h5, 4'h0, 4'h0, 4'h0, 4'h0, "t5_one_more");
    step(1'b1, 4'h5, 4'h0, 4'h0, 4'h0, 4'h0, "t5_second");
    step(1'b1, 4'h5, 4'h0, 4'h0, 4'h0, 4'h0, "t5_third");
    step(1'b1, 4'h5, 4'h0, 4'h5, 4'h5, 4'h0, "t5_rise");
    step(1'b1, 4'h5, 4'h0, 4'h5, 4'h0, 4'h0, "t5_hold");

`ifdef FILTER_BANK_IRQ_EN
    stepi(4'h5, 4'hF, 4'h5, 4'h0, 4'h0, 4'h0, "t6_clear_all");
    repeat (3) stepi(4'h4, 4'h0, 4'h5, 4'h0, 4'h0, 4'h0, "t6_lo_wait");
    stepi(4'h4, 4'h0, 4'h4, 4'h0, 4'h1, 4'h0, "t6_fall0");
    stepi(4'h4, 4'h0, 4'h4, 4'h0, 4'h0, 4'h1, "t6_fall0_pend");
    stepi(4'h4, 4'h1, 4'h4, 4'h0, 4'h0, 4'h0, "t6_clr0");
    repeat (3) stepi(4'h5, 4'h0, 4'h4, 4'h0, 4'h0, 4'h0, "t6_hi_wait");
    stepi(4'h5, 4'h0, 4'h5, 4'h1, 4'h0, 4'h0, "t6_rise0");
    stepi(4'h5, 4'h0, 4'h5, 4'h0, 4'h0, 4'h1, "t6_rise0_pend");
    repeat (3) stepi(4'h4, 4'h0, 4'h5, 4'h0, 4'h0, 4'h1, "t6_lo_wait2");
    stepi(4'h4, 4'h0, 4'h4, 4'h0, 4'h1, 4'h1, "t6_fall0b");
    stepi(4'h4, 4'h1, 4'h4, 4'h0, 4'h0, 4'h1, "t6_set_wins");
    stepi(4'h4, 4'h1, 4'h4, 4'h0, 4'h0, 4'h0, "t6_clr_idle");
    stepi(4'h4, 4'h0, 4'h4, 4'h0, 4'h0, 4'h0, "t6_quiet");
`endif

    step4(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "t4_reset");
    for (int n = 1; n <= 22; n++) begin
      step4(1'b1, (n == 3 || n == 4 || n >= 9), (n >= 21), (n == 21), 1'b0,
            ((n % 4) == 3), "t4_pre4_sync2");
    end

    repeat (3) @(posedge clock);
    @(negedge clock); #1;
    n_vec++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d pending entries required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
